// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on stall/flush, and global hold.
// Optional stall/flush event counters are enabled by defining HAZARD_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_Valid,
  input  logic [DATA_WIDTH-1:0] ID_PC,
  input  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr,
  input  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr,
  input  logic                  ID_Rs1_Used,
  input  logic                  ID_Rs2_Used,
  input  logic [ADDR_WIDTH-1:0] ID_Rd_Addr,
  input  logic [DATA_WIDTH-1:0] ID_Rs1_Data,
  input  logic [DATA_WIDTH-1:0] ID_Rs2_Data,
  input  logic [DATA_WIDTH-1:0] ID_Imm,
  input  logic [CTRL_WIDTH-1:0] ID_Ctrl,
  input  logic                  ID_Reg_w,
  input  logic                  ID_Mem_r,
  input  logic                  ID_Mem_w,
  input  logic                  Flush,
  input  logic                  Hold,
  output logic                  EX_Valid,
  output logic [DATA_WIDTH-1:0] EX_PC,
  output logic [ADDR_WIDTH-1:0] EX_Rs1_Addr,
  output logic [ADDR_WIDTH-1:0] EX_Rs2_Addr,
  output logic [ADDR_WIDTH-1:0] EX_Rd_Addr,
  output logic [DATA_WIDTH-1:0] EX_Rs1_Data,
  output logic [DATA_WIDTH-1:0] EX_Rs2_Data,
  output logic [DATA_WIDTH-1:0] EX_Imm,
  output logic [CTRL_WIDTH-1:0] EX_Ctrl,
  output logic                  EX_Reg_w,
  output logic                  EX_Mem_r,
  output logic                  EX_Mem_w,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           Stall_Cnt,
  output logic [31:0]           Flush_Cnt,
`endif
  output logic                  Stall
);

  logic                  ex_valid_q,    ex_valid_d;
  logic [DATA_WIDTH-1:0] ex_pc_q,       ex_pc_d;
  logic [ADDR_WIDTH-1:0] ex_rs1_addr_q, ex_rs1_addr_d;
  logic [ADDR_WIDTH-1:0] ex_rs2_addr_q, ex_rs2_addr_d;
  logic [ADDR_WIDTH-1:0] ex_rd_addr_q,  ex_rd_addr_d;
  logic [DATA_WIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [DATA_WIDTH-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [DATA_WIDTH-1:0] ex_imm_q,      ex_imm_d;
  logic [CTRL_WIDTH-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic                  ex_reg_w_q,    ex_reg_w_d;
  logic                  ex_mem_r_q,    ex_mem_r_d;
  logic                  ex_mem_w_q,    ex_mem_w_d;

  logic rs1_match;
  logic rs2_match;
  logic hazard;
  logic stall;
  logic bubble;

  // A load in EX whose rd feeds an ID source cannot be forwarded in time; x0 is never a real producer.
  always_comb begin
    rs1_match = ID_Rs1_Used && (ID_Rs1_Addr == ex_rd_addr_q);
    rs2_match = ID_Rs2_Used && (ID_Rs2_Addr == ex_rd_addr_q);
    hazard    = ex_valid_q && ex_mem_r_q && (ex_rd_addr_q != '0) && (rs1_match || rs2_match);
    stall     = hazard && ID_Valid && !Flush && !Hold;
    bubble    = Flush || stall || !ID_Valid;
  end

  assign Stall = stall;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_addr_d = ex_rs1_addr_q;
    ex_rs2_addr_d = ex_rs2_addr_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_reg_w_d    = ex_reg_w_q;
    ex_mem_r_d    = ex_mem_r_q;
    ex_mem_w_d    = ex_mem_w_q;
    if (!Hold) begin
      // Payload fields are loaded even for a bubble; only the qualifying control bits are cleared.
      ex_pc_d       = ID_PC;
      ex_rs1_addr_d = ID_Rs1_Addr;
      ex_rs2_addr_d = ID_Rs2_Addr;
      ex_rs1_data_d = ID_Rs1_Data;
      ex_rs2_data_d = ID_Rs2_Data;
      ex_imm_d      = ID_Imm;
      ex_ctrl_d     = ID_Ctrl;
      if (bubble) begin
        ex_valid_d   = 1'b0;
        ex_rd_addr_d = '0;
        ex_reg_w_d   = 1'b0;
        ex_mem_r_d   = 1'b0;
        ex_mem_w_d   = 1'b0;
      end else begin
        ex_valid_d   = 1'b1;
        ex_rd_addr_d = ID_Rd_Addr;
        ex_reg_w_d   = ID_Reg_w;
        ex_mem_r_d   = ID_Mem_r;
        ex_mem_w_d   = ID_Mem_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= '0;
      ex_reg_w_q    <= 1'b0;
      ex_mem_r_q    <= 1'b0;
      ex_mem_w_q    <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_addr_q <= ex_rs1_addr_d;
      ex_rs2_addr_q <= ex_rs2_addr_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_reg_w_q    <= ex_reg_w_d;
      ex_mem_r_q    <= ex_mem_r_d;
      ex_mem_w_q    <= ex_mem_w_d;
    end
  end

  assign EX_Valid    = ex_valid_q;
  assign EX_PC       = ex_pc_q;
  assign EX_Rs1_Addr = ex_rs1_addr_q;
  assign EX_Rs2_Addr = ex_rs2_addr_q;
  assign EX_Rd_Addr  = ex_rd_addr_q;
  assign EX_Rs1_Data = ex_rs1_data_q;
  assign EX_Rs2_Data = ex_rs2_data_q;
  assign EX_Imm      = ex_imm_q;
  assign EX_Ctrl     = ex_ctrl_q;
  assign EX_Reg_w    = ex_reg_w_q;
  assign EX_Mem_r    = ex_mem_r_q;
  assign EX_Mem_w    = ex_mem_w_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Stall already excludes Hold; Flush must be qualified here since it is ignored while held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (Flush && !Hold && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard testbench for id_ex_pipe_reg: a reference model predicts the EX register contents and Stall each cycle.
// Define HAZARD_PERF_CNT_EN to also exercise the event counters.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        reg_w;
    logic        mem_r;
    logic        mem_w;
  } ex_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       fl;
    logic       hd;
    logic       st;
  } row_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ID_Valid = 1'b0;
  logic [31:0] ID_PC = '0;
  logic [4:0]  ID_Rs1_Addr = '0;
  logic [4:0]  ID_Rs2_Addr = '0;
  logic        ID_Rs1_Used = 1'b0;
  logic        ID_Rs2_Used = 1'b0;
  logic [4:0]  ID_Rd_Addr = '0;
  logic [31:0] ID_Rs1_Data = '0;
  logic [31:0] ID_Rs2_Data = '0;
  logic [31:0] ID_Imm = '0;
  logic [7:0]  ID_Ctrl = '0;
  logic        ID_Reg_w = 1'b0;
  logic        ID_Mem_r = 1'b0;
  logic        ID_Mem_w = 1'b0;
  logic        Flush = 1'b0;
  logic        Hold = 1'b0;
  logic        EX_Valid;
  logic [31:0] EX_PC;
  logic [4:0]  EX_Rs1_Addr;
  logic [4:0]  EX_Rs2_Addr;
  logic [4:0]  EX_Rd_Addr;
  logic [31:0] EX_Rs1_Data;
  logic [31:0] EX_Rs2_Data;
  logic [31:0] EX_Imm;
  logic [7:0]  EX_Ctrl;
  logic        EX_Reg_w;
  logic        EX_Mem_r;
  logic        EX_Mem_w;
  logic        Stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Cnt;
  logic [31:0] Flush_Cnt;
  logic [31:0] exp_stall_cnt = '0;
  logic [31:0] exp_flush_cnt = '0;
`endif

  ex_t act;
  ex_t exp_cur = '0;
  ex_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  assign act = {EX_Valid, EX_PC, EX_Rs1_Addr, EX_Rs2_Addr, EX_Rd_Addr, EX_Rs1_Data, EX_Rs2_Data,
                EX_Imm, EX_Ctrl, EX_Reg_w, EX_Mem_r, EX_Mem_w};

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid), .ID_PC(ID_PC),
    .ID_Rs1_Addr(ID_Rs1_Addr), .ID_Rs2_Addr(ID_Rs2_Addr),
    .ID_Rs1_Used(ID_Rs1_Used), .ID_Rs2_Used(ID_Rs2_Used), .ID_Rd_Addr(ID_Rd_Addr),
    .ID_Rs1_Data(ID_Rs1_Data), .ID_Rs2_Data(ID_Rs2_Data), .ID_Imm(ID_Imm), .ID_Ctrl(ID_Ctrl),
    .ID_Reg_w(ID_Reg_w), .ID_Mem_r(ID_Mem_r), .ID_Mem_w(ID_Mem_w), .Flush(Flush), .Hold(Hold),
    .EX_Valid(EX_Valid), .EX_PC(EX_PC), .EX_Rs1_Addr(EX_Rs1_Addr), .EX_Rs2_Addr(EX_Rs2_Addr),
    .EX_Rd_Addr(EX_Rd_Addr), .EX_Rs1_Data(EX_Rs1_Data), .EX_Rs2_Data(EX_Rs2_Data),
    .EX_Imm(EX_Imm), .EX_Ctrl(EX_Ctrl), .EX_Reg_w(EX_Reg_w), .EX_Mem_r(EX_Mem_r),
    .EX_Mem_w(EX_Mem_w),
`ifdef HAZARD_PERF_CNT_EN
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt),
`endif
    .Stall(Stall)
  );

  function automatic row_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic mw, logic fl, logic hd,
                              logic st);
    row_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.mr = mr; r.mw = mw; r.fl = fl; r.hd = hd; r.st = st;
    return r;
  endfunction

  function automatic logic model_stall(ex_t cur);
    logic hz;
    hz = cur.valid && cur.mem_r && (cur.rd != 5'd0) &&
         ((ID_Rs1_Used && ID_Rs1_Addr == cur.rd) || (ID_Rs2_Used && ID_Rs2_Addr == cur.rd));
    return hz && ID_Valid && !Flush && !Hold;
  endfunction

  function automatic ex_t model_next(ex_t cur);
    ex_t n;
    logic kill;
    if (Hold) return cur;
    kill = Flush || model_stall(cur) || !ID_Valid;
    n.pc = ID_PC; n.rs1a = ID_Rs1_Addr; n.rs2a = ID_Rs2_Addr;
    n.rs1d = ID_Rs1_Data; n.rs2d = ID_Rs2_Data; n.imm = ID_Imm; n.ctrl = ID_Ctrl;
    n.valid = !kill;
    n.rd    = kill ? 5'd0 : ID_Rd_Addr;
    n.reg_w = !kill && ID_Reg_w;
    n.mem_r = !kill && ID_Mem_r;
    n.mem_w = !kill && ID_Mem_w;
    return n;
  endfunction

  task automatic tick();
`ifdef HAZARD_PERF_CNT_EN
    if (model_stall(exp_cur) && exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt = exp_stall_cnt + 1;
    if (Flush && !Hold && exp_flush_cnt != 32'hFFFF_FFFF) exp_flush_cnt = exp_flush_cnt + 1;
`endif
    exp_cur = model_next(exp_cur);
    sb.push_back(exp_cur);
    @(posedge clk);
    #1;
  endtask

  // Drives one ID row, samples Stall before the edge, clocks, and hands back the expected EX state.
  task automatic apply_row(input row_t r, output logic st_seen, output ex_t e);
    ID_Valid = r.v; ID_Rs1_Addr = r.rs1; ID_Rs1_Used = r.u1; ID_Rs2_Addr = r.rs2; ID_Rs2_Used = r.u2;
    ID_Rd_Addr = r.rd; ID_Reg_w = r.rw; ID_Mem_r = r.mr; ID_Mem_w = r.mw; Flush = r.fl; Hold = r.hd;
    ID_PC = $urandom; ID_Rs1_Data = $urandom; ID_Rs2_Data = $urandom; ID_Imm = $urandom;
    ID_Ctrl = 8'($urandom);
    #1;
    st_seen = Stall;
    tick();
    if (sb.size() == 0) begin
      e = exp_cur;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    #2;
    ID_Valid = 1'b1; ID_PC = $urandom; ID_Rs1_Addr = 5'd3; ID_Rs1_Used = 1'b1; ID_Rd_Addr = 5'd9;
    ID_Rs1_Data = $urandom; ID_Imm = $urandom; ID_Reg_w = 1'b1; ID_Mem_r = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (act !== '0) begin n_fail++; $display("FAIL reset_async: got %h want 0", act); end
    n_checks++;
    if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall); end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", Stall_Cnt, Flush_Cnt);
    end
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if (act !== '0) begin n_fail++; $display("FAIL reset_held: got %h want 0", act); end
    rst_n = 1'b1;
    exp_cur = '0;
    sb.delete();
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic st;
    ex_t e;
    rows.push_back(mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply_row(rows[i], st, e);
      n_checks++;
      if (st !== rows[i].st) begin n_fail++; $display("FAIL load_use_stall[%0d]: got %b want %b", i, st, rows[i].st); end
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL load_use_ex[%0d]: got %h want %h", i, act, e); end
      n_checks++;
      if (i == 0 && !(EX_Mem_r === 1'b1 && EX_Rd_Addr === 5'd5)) begin
        n_fail++; $display("FAIL load_use_load: got mem_r=%b rd=%0d want 1/5", EX_Mem_r, EX_Rd_Addr);
      end else if (i == 1 && !(EX_Valid === 1'b0 && EX_Rd_Addr === 5'd0)) begin
        n_fail++; $display("FAIL load_use_bubble: got valid=%b rd=%0d want 0/0", EX_Valid, EX_Rd_Addr);
      end else if (i == 2 && !(EX_Rs1_Addr === 5'd5 && EX_Rd_Addr === 5'd6 && EX_Valid === 1'b1)) begin
        n_fail++; $display("FAIL load_use_issue: got rs1=%0d rd=%0d want 5/6", EX_Rs1_Addr, EX_Rd_Addr);
      end
    end
  endtask

  task automatic test_x0();
    row_t rows[$];
    logic st;
    ex_t e;
    rows.push_back(mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply_row(rows[i], st, e);
      n_checks++;
      if (st !== rows[i].st) begin n_fail++; $display("FAIL x0_stall[%0d]: got %b want %b", i, st, rows[i].st); end
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL x0_ex[%0d]: got %h want %h", i, act, e); end
    end
    n_checks++;
    if (EX_Valid !== 1'b1 || EX_Rd_Addr !== 5'd7) begin
      n_fail++; $display("FAIL x0_no_bubble: got valid=%b rd=%0d want 1/7", EX_Valid, EX_Rd_Addr);
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic st;
    ex_t e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] s0, f0;
`endif
    rows.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
`ifdef HAZARD_PERF_CNT_EN
      s0 = Stall_Cnt; f0 = Flush_Cnt;
`endif
      apply_row(rows[i], st, e);
      n_checks++;
      if (st !== rows[i].st) begin n_fail++; $display("FAIL flush_stall[%0d]: got %b want %b", i, st, rows[i].st); end
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL flush_ex[%0d]: got %h want %h", i, act, e); end
      n_checks++;
      if (i == 1 && (EX_Valid !== 1'b0 || EX_Mem_w !== 1'b0 || EX_Rd_Addr !== 5'd0)) begin
        n_fail++; $display("FAIL flush_bubble: got valid=%b mem_w=%b rd=%0d want 0/0/0", EX_Valid, EX_Mem_w, EX_Rd_Addr);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (i == 1 && (Flush_Cnt !== f0 + 32'd1 || Stall_Cnt !== s0)) begin
        n_fail++; $display("FAIL flush_cnt: got %h/%h want %h/%h", Flush_Cnt, Stall_Cnt, f0 + 32'd1, s0);
      end
`endif
    end
  endtask

  task automatic test_hold();
    row_t rows[$];
    logic st;
    ex_t e;
    ex_t snap;
    rows.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    snap = '0;
    foreach (rows[i]) begin
      apply_row(rows[i], st, e);
      n_checks++;
      if (st !== rows[i].st) begin n_fail++; $display("FAIL hold_stall[%0d]: got %b want %b", i, st, rows[i].st); end
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL hold_ex[%0d]: got %h want %h", i, act, e); end
      if (i == 0) snap = act;
      n_checks++;
      if (rows[i].hd && act !== snap) begin
        n_fail++; $display("FAIL hold_frozen[%0d]: got %h want %h", i, act, snap);
      end else if (i == 4 && (EX_Rd_Addr !== 5'd11 || EX_Rs2_Addr !== 5'd10 || EX_Valid !== 1'b1)) begin
        n_fail++; $display("FAIL hold_release: got rd=%0d rs2=%0d want 11/10", EX_Rd_Addr, EX_Rs2_Addr);
      end
    end
    Hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic st;
    ex_t e;
    int stalls;
    rows.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd8, 1'b0, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    stalls = 0;
    foreach (rows[i]) begin
      apply_row(rows[i], st, e);
      if (st === 1'b1) stalls++;
      n_checks++;
      if (st !== rows[i].st) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b want %b", i, st, rows[i].st); end
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL b2b_ex[%0d]: got %h want %h", i, act, e); end
    end
    n_checks++;
    if (stalls != 3) begin n_fail++; $display("FAIL b2b_stall_total: got %0d want 3", stalls); end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    logic st;
    ex_t e;
    rows.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    apply_row(rows[0], st, e);
    n_checks++;
    if (act !== e) begin n_fail++; $display("FAIL mid_reset_fill: got %h want %h", act, e); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (act !== '0) begin n_fail++; $display("FAIL mid_reset_clear: got %h want 0", act); end
    rst_n = 1'b1;
    exp_cur = '0;
`ifdef HAZARD_PERF_CNT_EN
    exp_stall_cnt = '0;
    exp_flush_cnt = '0;
`endif
    apply_row(rows[1], st, e);
    n_checks++;
    if (st !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stall: got %b want 0", st); end
    n_checks++;
    if (act !== e || EX_Rd_Addr !== 5'd6) begin n_fail++; $display("FAIL mid_reset_load: got %h want %h", act, e); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_cnt_saturate();
    row_t rows[$];
    logic st;
    ex_t e;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_stall_cnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      rows.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'(20 + k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      rows.push_back(mk(1'b1, 5'(20 + k), 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      rows.push_back(mk(1'b1, 5'(20 + k), 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    foreach (rows[i]) begin
      apply_row(rows[i], st, e);
      n_checks++;
      if (st !== rows[i].st) begin n_fail++; $display("FAIL sat_stall[%0d]: got %b want %b", i, st, rows[i].st); end
      n_checks++;
      if (Stall_Cnt !== exp_stall_cnt) begin
        n_fail++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, Stall_Cnt, exp_stall_cnt);
      end
    end
    n_checks++;
    if (Stall_Cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_final: got %h want ffffffff", Stall_Cnt); end
    n_checks++;
    if (Flush_Cnt !== exp_flush_cnt) begin n_fail++; $display("FAIL flush_cnt_final: got %h want %h", Flush_Cnt, exp_flush_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
    test_cnt_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
